regfl_2r1w: RTL

// - Parametrised 2-read/1-write register file for the IPU data path; the next generation of the single-port register file.
// - Adds: two independently addressed, registered read ports; write-to-read bypass; optional hard-wired zero register.
// - Adds a sequenced clear-all sweep: one register per cycle, with busy/done status.
// - Sits between the operand-fetch stage and the ALU writeback; the controller issues clr_req at context switch.
//

---
 rtl/ipu_pkg.sv | 22 ++
 rtl/regfl_2r1w_if.sv | 37 +++
 rtl/regfl_clr_fsm.sv | 72 +++++++
 rtl/regfl_2r1w.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// ----------------------------------------------------------------------------
// ipu_pkg
// Shared definitions for the IPU register file: default geometry and the
// clear-sweep FSM state encoding.
// ----------------------------------------------------------------------------
package ipu_pkg;

    localparam int IPU_W      = 3;   // address width, depth = 2**IPU_W
    localparam int IPU_RGST_W = 64;  // register data width

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CLR  = 2'b01,
        ST_DONE = 2'b10
    } clr_state_e;

    // Number of registers for a given address width.
    function automatic int unsigned regfl_depth(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/regfl_2r1w_if.sv
// ----------------------------------------------------------------------------
// regfl_2r1w_if
// Bus bundle of the 2-read/1-write register file.
//   master : write port (we/wa/wd), read requests (re0/ra0, re1/ra1), clr_req
//   slave  : registered read data (rd0/rd1), sweep status (busy, clr_done),
//            discarded-write pulse (wr_drop)
// ----------------------------------------------------------------------------
interface regfl_2r1w_if import ipu_pkg::*; #(
    parameter int W      = IPU_W,
    parameter int RGST_W = IPU_RGST_W
);

    logic              we;
    logic [W-1:0]      wa;
    logic [RGST_W-1:0] wd;
    logic              re0;
    logic [W-1:0]      ra0;
    logic              re1;
    logic [W-1:0]      ra1;
    logic [RGST_W-1:0] rd0;
    logic [RGST_W-1:0] rd1;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
    logic              wr_drop;

    modport master (
        output we, wa, wd, re0, ra0, re1, ra1, clr_req,
        input  rd0, rd1, busy, clr_done, wr_drop
    );

    modport slave (
        input  we, wa, wd, re0, ra0, re1, ra1, clr_req,
        output rd0, rd1, busy, clr_done, wr_drop
    );

endinterface

// File: rtl/regfl_clr_fsm.sv
// ----------------------------------------------------------------------------
// regfl_clr_fsm
// Clear-all sequencer: walks a W-bit counter over every register address,
// one per cycle, then emits a one-cycle done pulse.
//   clk, rst_b    : clock, asynchronous active-low reset
//   clr_req_i     : start a sweep (only honoured while idle)
//   idle_o        : FSM is idle; user writes and bypass are allowed
//   busy_o        : sweep in progress (registered state decode)
//   clr_done_o    : single-cycle pulse after the last address is cleared
//   clr_we_o      : write strobe for the array clear
//   clr_addr_o    : address being cleared this cycle
// ----------------------------------------------------------------------------
module regfl_clr_fsm import ipu_pkg::*; #(
    parameter int W = IPU_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr_req_i,
    output logic         idle_o,
    output logic         busy_o,
    output logic         clr_done_o,
    output logic         clr_we_o,
    output logic [W-1:0] clr_addr_o
);

    clr_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            ST_CLR: begin
                // Counter wraps back to 0 on the last address, leaving it
                // ready for the next sweep.
                cnt_d = cnt_q + W'(1);
                if (cnt_q == {W{1'b1}}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idle_o     = (state_q == ST_IDLE);
    assign busy_o     = (state_q == ST_CLR);
    assign clr_done_o = (state_q == ST_DONE);
    assign clr_we_o   = (state_q == ST_CLR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfl_2r1w.sv
// ----------------------------------------------------------------------------
// regfl_2r1w
// Parametrised 2-read/1-write register file for the IPU data path.
//   clk, rst_b : clock (rising edge), asynchronous active-low reset
//   bus.slave  : write port we/wa/wd; read ports re0/ra0 -> rd0 and
//                re1/ra1 -> rd1 (registered, one-cycle latency); clr_req
//                starts a clear-all sweep reported through busy/clr_done;
//                wr_drop flags a write discarded while the sweep owns the array
// Parameters:
//   W      address width (depth = 2**W)
//   RGST_W register width
//   ZERO_R 1: register 0 is hard-wired to zero
//   BYPASS 1: same-cycle write data is forwarded to a matching read
// ----------------------------------------------------------------------------
module regfl_2r1w import ipu_pkg::*; #(
    parameter int W      = IPU_W,
    parameter int RGST_W = IPU_RGST_W,
    parameter bit ZERO_R = 1'b0,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_b,
    regfl_2r1w_if.slave  bus
);

    localparam int DEPTH = int'(regfl_depth(W));

    logic              idle;
    logic              busy;
    logic              clr_done;
    logic              clr_we;
    logic [W-1:0]      clr_addr;

    logic              usr_we;
    logic              wr_en;
    logic [W-1:0]      wr_addr;
    logic [RGST_W-1:0] wr_data;
    logic [DEPTH-1:0]  wr_sel;

    logic [RGST_W-1:0] regs_q [DEPTH];

    logic              re   [2];
    logic [W-1:0]      ra   [2];
    logic [RGST_W-1:0] rd_d [2];
    logic [RGST_W-1:0] rd_q [2];

    regfl_clr_fsm #(
        .W (W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_b      (rst_b),
        .clr_req_i  (bus.clr_req),
        .idle_o     (idle),
        .busy_o     (busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // User writes only land while idle; a write to the hard-wired zero
    // register is silently dropped (it is not a wr_drop event).
    assign usr_we = bus.we & idle & ~(ZERO_R && (bus.wa == '0));

    // The sweep owns the write port while it runs.
    assign wr_en   = clr_we | usr_we;
    assign wr_addr = clr_we ? clr_addr : bus.wa;
    assign wr_data = clr_we ? '0 : bus.wd;

    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    assign re[0] = bus.re0;
    assign re[1] = bus.re1;
    assign ra[0] = bus.ra0;
    assign ra[1] = bus.ra1;

    // Read data next-state; the zero register check comes first so it also
    // overrides the bypass path.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = rd_q[p];
            if (re[p]) begin
                if (ZERO_R && (ra[p] == '0)) begin
                    rd_d[p] = '0;
                end else if (BYPASS && bus.we && idle && (ra[p] == bus.wa)) begin
                    rd_d[p] = bus.wd;
                end else begin
                    rd_d[p] = regs_q[ra[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int p = 0; p < 2; p++) begin
                rd_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                rd_q[p] <= rd_d[p];
            end
        end
    end

    assign bus.rd0      = rd_q[0];
    assign bus.rd1      = rd_q[1];
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done;
    // Any write attempted while the sweep or its done cycle is active is lost.
    assign bus.wr_drop  = bus.we & ~idle;

endmodule
